pattern_source: RTL and testbench
=================================

# pattern_source

Raster pattern generator for the 16x16 pixel grid: on each frame-start pulse it emits all 256 pixels as `(x, y, rgb)` beats over a valid/ready handshake. It is the producer end of the pixel stream that `pattern_modifier` consumes, and it drives that block's `xin`/`yin`/`rgbin`. A per-frame offset counter animates the gradient and checker patterns.

## Interface
Parameters:
- `SOLID_COLOR`, default 5'd31: colour used by the solid and checker modes.
- `OFFSET_STEP`, default 5'd1: amount added to the animation offset after each completed frame.

Ports:
- `fclock`  in  1  sole clock; all logic is on the rising edge.
- `init`  in  1  reset, asynchronous, active-low.
- `start`  in  1  frame-start request (one-cycle pulse).
- `mode`  in  2  pattern select; sampled only when a start is accepted.
- `ready`  in  1  downstream accepts the current beat.
- `valid`  out  1  current beat is valid.
- `x`  out  4  pixel column.
- `y`  out  4  pixel row.
- `rgb`  out  5  pixel colour index.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- `overrun`  out  1  sticky flag: a `start` arrived while `busy` was high.

## Operation
- States:
  - IDLE: `valid`=0.
  - SCAN: a frame is being emitted.
- IDLE→SCAN: on `start`=1. The block latches `mode` into `mode_q` and loads scan position (0,0).
- Handshake:
  - A beat transfers on `valid && ready`.
  - While `valid`=1 and `ready`=0, `x`, `y` and `rgb` hold stable.
  - `valid` never drops mid-frame.
- Scan order: `x` increments 0..15, then wraps to 0 while `y` increments. Frame ends when beat (15,15) transfers.
- Last transfer: SCAN→IDLE, `frame_done`=1 for one cycle, `offset` ← `offset + OFFSET_STEP` (mod 32).
- Colour (5-bit arithmetic, mod 32):
  - SOLID (0): `rgb` = `SOLID_COLOR`.
  - HGRAD (1): `rgb` = `{1'b0,x} + offset`.
  - VGRAD (2): `rgb` = `{1'b0,y} + offset`.
  - CHECK (3): `rgb` = (`x[0]^y[0]^offset[0]`) ? `SOLID_COLOR` : 0.
- `start` while in SCAN:
  - Ignored: the frame continues and `mode_q` is unchanged.
  - `overrun` ← 1.
  - This includes the cycle of the last transfer.
- `mode` changes during SCAN have no effect.
- `overrun` is cleared only by `init`.
- Reset mid-frame (`init`=0) aborts immediately, with no `frame_done`.

## Timing
- Reset values: `valid`=0, `x`=0, `y`=0, `rgb`=0, `busy`=0, `frame_done`=0, `overrun`=0. Internal: `offset`=0, state IDLE.
- All outputs are registered.
- `start` sampled at edge N → `valid`=1 and `busy`=1 from cycle N+1, presenting (0,0).
- With `ready` held at 1, one beat transfers per cycle. A frame takes 256 cycles.
- Last transfer at edge M → at cycle M+1: `valid`=0, `busy`=0, `frame_done`=1, and the new `offset` is visible. `start` in cycle M+1 is accepted.
- `rgb` is computed from the next `(x, y)` and the current `offset`, and registered together with them. There is no extra latency.

## Configuration
- `PATTERN_SOURCE_SERPENTINE_EN`:
  - Defined: rows with odd `y` scan `x` from 15 down to 0, matching serpentine-wired LED strips. The frame ends at (0,15). Colour formulas use the emitted `x`.
  - Undefined: all rows scan 0→15 and the frame ends at (15,15).

## Structure
- Shared package `pattern_pkg`:
  - Constants: `GRID_DIM`=16, `COORD_W`=4, `RGB_W`=5.
  - Mode enum `pattern_mode_t`: SOLID=0, HGRAD=1, VGRAD=2, CHECK=3.
  - The same constants are used by `pattern_modifier`.
- One sub-module: `raster_counter`.
  - Holds the x/y counters with advance enable, wrap, serpentine handling and a `last` flag.
  - `pattern_source` holds the FSM, colour logic, offset and flags.

## Test plan
- Reset, HGRAD, `ready`=1, `start` pulse:
  - `valid` rises the next cycle at (0,0) with rgb=0.
  - 256 consecutive beats follow; the beat at (15,3) has rgb=15.
  - `frame_done` pulses once.
  - A second frame at (0,0) has rgb=1.
- VGRAD with `ready` toggled randomly:
  - `x`/`y`/`rgb` are stable whenever `ready`=0.
  - Beat count is exactly 256 and row 15 has rgb=15.
- CHECK, `SOLID_COLOR`=31: (0,0)→0, (1,0)→31, (1,1)→0. Frame 2 inverts: (0,0)→31.
- `start` at beat 100 of a SOLID frame:
  - The frame completes normally with 256 beats and `overrun`=1.
  - `overrun` stays set until `init`.
- `init` low at beat 50:
  - All outputs return to their reset values with no `frame_done`.
  - A subsequent `start` begins at (0,0) with offset 0.
- With `PATTERN_SOURCE_SERPENTINE_EN`:
  - Row 1 emits x=15..0.
  - The last beat is (0,15), followed by `frame_done`.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared constants, mode encoding and colour rule for the 16x16 pixel stream
// produced by pattern_source and consumed by pattern_modifier.
package pattern_pkg;

   localparam int GRID_DIM = 16;
   localparam int COORD_W  = 4;
   localparam int RGB_W    = 5;

   typedef enum logic [1:0] {
      SOLID = 2'd0,
      HGRAD = 2'd1,
      VGRAD = 2'd2,
      CHECK = 2'd3
   } pattern_mode_t;

   // Colour index of one pixel; all arithmetic wraps modulo 2**RGB_W.
   function automatic logic [RGB_W-1:0] pattern_rgb(
      input pattern_mode_t      mode,
      input logic [COORD_W-1:0] px,
      input logic [COORD_W-1:0] py,
      input logic [RGB_W-1:0]   offset,
      input logic [RGB_W-1:0]   solid
   );
      logic [RGB_W-1:0] c;
      case (mode)
         SOLID:   c = solid;
         HGRAD:   c = {1'b0, px} + offset;
         VGRAD:   c = {1'b0, py} + offset;
         default: c = (px[0] ^ py[0] ^ offset[0]) ? solid : '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter with clear, advance and end-of-frame flag.
// Optional PATTERN_SOURCE_SERPENTINE_EN reverses x on odd rows.
module raster_counter
   import pattern_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               adv_i,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic [COORD_W-1:0] nx_o,
   output logic [COORD_W-1:0] ny_o,
   output logic               last_o
);

   localparam logic [COORD_W-1:0] CMAX = COORD_W'(GRID_DIM - 1);
   localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

   logic [COORD_W-1:0] x_q, y_q, x_d, y_d;

   // Next position is exported so the colour can be registered alongside it.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear_i) begin
         x_d = '0;
         y_d = '0;
      end else if (adv_i) begin
`ifdef PATTERN_SOURCE_SERPENTINE_EN
         if (y_q[0]) begin
            if (x_q == '0) y_d = y_q + ONE;
            else           x_d = x_q - ONE;
         end else begin
            if (x_q == CMAX) y_d = y_q + ONE;
            else             x_d = x_q + ONE;
         end
`else
         x_d = x_q + ONE;
         if (x_q == CMAX) y_d = y_q + ONE;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

`ifdef PATTERN_SOURCE_SERPENTINE_EN
   assign last_o = (y_q == CMAX) && (x_q == '0);
`else
   assign last_o = (y_q == CMAX) && (x_q == CMAX);
`endif

   assign x_o  = x_q;
   assign y_o  = y_q;
   assign nx_o = x_d;
   assign ny_o = y_d;

endmodule

// File: rtl/pattern_source.sv
// 16x16 raster pattern generator streaming (x, y, rgb) beats over valid/ready.
// Build option PATTERN_SOURCE_SERPENTINE_EN selects serpentine scan order.
module pattern_source
   import pattern_pkg::*;
#(
   parameter logic [RGB_W-1:0] SOLID_COLOR = 5'd31,
   parameter logic [RGB_W-1:0] OFFSET_STEP = 5'd1
) (
   input  logic               fclock,
   input  logic               init,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic               ready,
   output logic               valid,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [RGB_W-1:0]   rgb,
   output logic               busy,
   output logic               frame_done,
   output logic               overrun
);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t             state_q;
   pattern_mode_t      mode_q, mode_d;
   logic               valid_q, busy_q, done_q, ovr_q;
   logic [RGB_W-1:0]   offset_q, rgb_q;
   logic               fire, last, start_acc, cnt_adv;
   logic [COORD_W-1:0] nx, ny;

   assign fire      = valid_q & ready;
   assign start_acc = (state_q == IDLE) & start;
   assign cnt_adv   = (state_q == SCAN) & fire & ~last;
   assign mode_d    = start_acc ? pattern_mode_t'(mode) : mode_q;

   raster_counter u_raster (
      .clk_i   (fclock),
      .rst_ni  (init),
      .clear_i (start_acc),
      .adv_i   (cnt_adv),
      .x_o     (x),
      .y_o     (y),
      .nx_o    (nx),
      .ny_o    (ny),
      .last_o  (last)
   );

   always_ff @(posedge fclock or negedge init) begin
      if (!init) begin
         state_q  <= IDLE;
         mode_q   <= SOLID;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         offset_q <= '0;
         rgb_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_acc || cnt_adv)
            rgb_q <= pattern_rgb(mode_d, nx, ny, offset_q, SOLID_COLOR);
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SCAN;
                  mode_q  <= mode_d;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            SCAN: begin
               // A start during a frame is dropped but remembered, including on the last beat.
               if (start) ovr_q <= 1'b1;
               if (fire && last) begin
                  state_q  <= IDLE;
                  valid_q  <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  offset_q <= offset_q + OFFSET_STEP;
               end
            end
         endcase
      end
   end

   assign valid      = valid_q;
   assign rgb        = rgb_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_pattern_source.sv
// Scoreboard bench for pattern_source: a frame-level reference model queues
// expected beats on each accepted start; a negedge monitor checks every transfer.
`timescale 1ns/1ps
module tb_pattern_source;

   localparam int SOLID_C = 31;
   localparam int STEP    = 1;
   localparam int NBEATS  = 256;

   logic       fclock = 1'b0;
   logic       init   = 1'b0;
   logic       start  = 1'b0;
   logic [1:0] mode   = 2'd0;
   logic       ready  = 1'b1;
   logic       valid, busy, frame_done, overrun;
   logic [3:0] x, y;
   logic [4:0] rgb;

   pattern_source dut (
      .fclock     (fclock),
      .init       (init),
      .start      (start),
      .mode       (mode),
      .ready      (ready),
      .valid      (valid),
      .x          (x),
      .y          (y),
      .rgb        (rgb),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 fclock = ~fclock;

   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic [4:0] rgb;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_e, held;
   int    checks = 0;
   int    errors = 0;
   int    offset_m = 0;
   bit    ovr_m = 1'b0;
   bit    done_pending = 1'b0;
   bit    scan_at_edge = 1'b0;
   bit    stall_prev = 1'b0;
   bit    rand_ready = 1'b0;
   int    frames_done = 0;
   int    beat_idx = 0;
   logic [3:0] cap_x [NBEATS];
   logic [3:0] cap_y [NBEATS];
   logic [4:0] grid_rgb [NBEATS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int model_rgb(input int m, input int px, input int py, input int off);
      case (m)
         0:       return SOLID_C;
         1:       return (px + off) % 32;
         2:       return (py + off) % 32;
         default: return (((px + py + off) % 2) == 1) ? SOLID_C : 0;
      endcase
   endfunction

   task automatic push_frame(input int m);
      for (int b = 0; b < NBEATS; b++) begin
         int py;
         int px;
         beat_t e;
         py = b / 16;
         px = b % 16;
`ifdef PATTERN_SOURCE_SERPENTINE_EN
         if (py % 2 == 1) px = 15 - px;
`endif
         e.x   = 4'(px);
         e.y   = 4'(py);
         e.rgb = 5'(model_rgb(m, px, py, offset_m));
         exp_q.push_back(e);
      end
   endtask

   // Monitor: transfers happen at the posedge following a negedge with valid && ready.
   always @(negedge fclock) begin
      if (!init) begin
         check("rst_valid", {31'd0, valid}, 0);
         check("rst_busy", {31'd0, busy}, 0);
         check("rst_frame_done", {31'd0, frame_done}, 0);
         check("rst_overrun", {31'd0, overrun}, 0);
         check("rst_xy_rgb", {19'd0, x, y, rgb}, 0);
         stall_prev   = 1'b0;
         scan_at_edge = 1'b0;
         done_pending = 1'b0;
      end else begin
         check("valid", {31'd0, valid}, {31'd0, exp_q.size() != 0});
         check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
         check("frame_done", {31'd0, frame_done}, {31'd0, done_pending});
         check("overrun", {31'd0, overrun}, {31'd0, ovr_m});
         if (frame_done) frames_done++;
         done_pending = 1'b0;
         if (stall_prev && valid)
            check("hold_stable", {19'd0, x, y, rgb}, {19'd0, held});
         stall_prev   = valid && !ready;
         held.x       = x;
         held.y       = y;
         held.rgb     = rgb;
         scan_at_edge = (exp_q.size() != 0);
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_x", {28'd0, x}, {28'd0, mon_e.x});
               check("beat_y", {28'd0, y}, {28'd0, mon_e.y});
               check("beat_rgb", {27'd0, rgb}, {27'd0, mon_e.rgb});
               if (beat_idx < NBEATS) begin
                  cap_x[beat_idx] = x;
                  cap_y[beat_idx] = y;
               end
               grid_rgb[{y, x}] = rgb;
               beat_idx++;
               if (exp_q.size() == 0) begin
                  done_pending = 1'b1;
                  offset_m     = (offset_m + STEP) % 32;
               end
            end
         end
      end
   end

   always @(posedge fclock) begin
      #1;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // All driver tasks are entered and left at posedge + 1.
   task automatic pulse_start(input int m);
      mode  = 2'(m);
      start = 1'b1;
      @(posedge fclock);
      #1;
      start = 1'b0;
      if (scan_at_edge) begin
         ovr_m = 1'b1;
      end else begin
         beat_idx = 0;
         push_frame(m);
      end
   endtask

   task automatic wait_done(input int target, input int budget);
      int c;
      c = 0;
      while (frames_done < target && c < budget) begin
         @(posedge fclock);
         #1;
         c++;
      end
      check("frame_done_seen", {31'd0, frames_done >= target}, 1);
   endtask

   task automatic wait_beat(input int n, input int budget);
      int c;
      c = 0;
      while (beat_idx < n && c < budget) begin
         @(posedge fclock);
         #1;
         c++;
      end
      check("beat_reached", {31'd0, beat_idx >= n}, 1);
   endtask

   task automatic do_reset();
      init = 1'b0;
      exp_q.delete();
      offset_m     = 0;
      ovr_m        = 1'b0;
      done_pending = 1'b0;
      repeat (3) @(posedge fclock);
      #1;
      init = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int target;
      int m;
      repeat (3) @(posedge fclock);
      #1;
      check("reset_state", {26'd0, valid, busy, frame_done, overrun, 2'b00}, 0);
      check("reset_xyrgb", {19'd0, x, y, rgb}, 0);
      init = 1'b1;
      @(posedge fclock);
      #1;

      // HGRAD, ready held high
      pulse_start(1);
      check("first_valid", {31'd0, valid}, 1);
      check("first_xy", {24'd0, x, y}, 0);
      check("first_rgb", {27'd0, rgb}, 0);
      wait_done(1, 400);
      check("hgrad_beats", beat_idx, NBEATS);
      check("hgrad_15_3", {27'd0, grid_rgb[{4'd3, 4'd15}]}, 15);
`ifdef PATTERN_SOURCE_SERPENTINE_EN
      check("serp_row1_first", {28'd0, cap_x[16]}, 15);
      check("serp_row1_last", {28'd0, cap_x[31]}, 0);
      check("serp_last_beat", {24'd0, cap_x[255], cap_y[255]}, {24'd0, 4'd0, 4'd15});
`else
      check("row1_first", {28'd0, cap_x[16]}, 0);
      check("last_beat", {24'd0, cap_x[255], cap_y[255]}, {24'd0, 4'd15, 4'd15});
`endif
      pulse_start(1);
      check("hgrad2_rgb00", {27'd0, rgb}, 1);
      wait_done(2, 400);
      check("hgrad2_0_0", {27'd0, grid_rgb[0]}, 1);

      // VGRAD with random backpressure
      do_reset();
      rand_ready = 1'b1;
      pulse_start(2);
      wait_done(3, 3000);
      rand_ready = 1'b0;
      check("vgrad_beats", beat_idx, NBEATS);
      check("vgrad_row15_a", {27'd0, grid_rgb[{4'd15, 4'd0}]}, 15);
      check("vgrad_row15_b", {27'd0, grid_rgb[{4'd15, 4'd9}]}, 15);

      // CHECK pattern, two frames
      do_reset();
      pulse_start(3);
      wait_done(4, 400);
      check("check_0_0", {27'd0, grid_rgb[{4'd0, 4'd0}]}, 0);
      check("check_1_0", {27'd0, grid_rgb[{4'd0, 4'd1}]}, 31);
      check("check_1_1", {27'd0, grid_rgb[{4'd1, 4'd1}]}, 0);
      pulse_start(3);
      wait_done(5, 400);
      check("check2_0_0", {27'd0, grid_rgb[{4'd0, 4'd0}]}, 31);

      // start mid-frame: ignored, sets sticky overrun
      pulse_start(0);
      wait_beat(100, 400);
      pulse_start(3);
      check("overrun_set", {31'd0, overrun}, 1);
      wait_done(6, 400);
      check("overrun_beats", beat_idx, NBEATS);
      repeat (5) @(posedge fclock);
      #1;
      check("overrun_sticky", {31'd0, overrun}, 1);

      // reset in the middle of a frame
      pulse_start(1);
      wait_beat(50, 400);
      target = frames_done;
      do_reset();
      check("midrst_outputs", {26'd0, valid, busy, frame_done, overrun, 2'b00}, 0);
      check("midrst_xyrgb", {19'd0, x, y, rgb}, 0);
      repeat (4) @(posedge fclock);
      #1;
      check("midrst_no_done", frames_done, target);
      pulse_start(1);
      check("midrst_restart", {19'd0, x, y, rgb}, 0);
      wait_done(target + 1, 400);

      // randomized modes, backpressure and idle gaps
      for (int i = 0; i < 3; i++) begin
         m = int'($urandom_range(0, 3));
         rand_ready = 1'b1;
         repeat (int'($urandom_range(0, 4))) @(posedge fclock);
         #1;
         target = frames_done + 1;
         pulse_start(m);
         wait_done(target, 3000);
         check("rand_beats", beat_idx, NBEATS);
      end
      rand_ready = 1'b0;
      repeat (3) @(posedge fclock);
      #1;
      check("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
